// File: rtl/line_fill_unit_pkg.sv
// Shared definitions for the line fill path (cache, fill unit, word selector).
// Provides the fill FSM state encoding and the line/word geometry constants.
package line_fill_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned WORDS_PER_LINE = 4;
    localparam int unsigned WORD_W         = 16;
    localparam int unsigned LINE_W         = 64;
    localparam int unsigned IDX_W          = 2;

endpackage

// File: rtl/line_fill_unit.sv
// line_fill_unit: fetches one 64-bit line from 16-bit main memory as four
// sequential word reads, assembles it bottom-up and hands it to the cache
// with a valid/ready handshake.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   fill_req, fill_addr   line fill request and line address (accepted in IDLE)
//   fill_busy             high whenever a fill or handoff is in progress
//   flush                 abort current fill, discard data
//   mem_req, mem_addr     memory word read request / word address
//   mem_ack, mem_data     memory acknowledge with same-cycle read data
//   line_valid, line_ready, line_data, line_addr   line handoff to the cache
module line_fill_unit
    import line_fill_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fill_req,
    input  logic [ADDR_W-IDX_W-1:0]   fill_addr,
    output logic                      fill_busy,
    input  logic                      flush,
    output logic                      mem_req,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic                      mem_ack,
    input  logic [WORD_W-1:0]         mem_data,
    output logic                      line_valid,
    input  logic                      line_ready,
    output logic [LINE_W-1:0]         line_data,
    output logic [ADDR_W-IDX_W-1:0]   line_addr
);

    localparam int unsigned LADDR_W = ADDR_W - IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);

    state_t               state;
    state_t               state_n;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     idx_n;
    logic [LADDR_W-1:0]   addr_n;
    logic [LINE_W-1:0]    data_n;
    logic [WORDS_PER_LINE-1:0] slot_en;

    // Next-state, word index, address latch and slot-write decode
    always_comb begin
        state_n = state;
        idx_n   = idx;
        addr_n  = line_addr;
        slot_en = '0;

        if (flush) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (fill_req) begin
                        state_n = FILL;
                        addr_n  = fill_addr;
                        idx_n   = '0;
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        slot_en = WORDS_PER_LINE'(1) << idx;
                        idx_n   = idx + IDX_W'(1);
                        if (idx == LAST_IDX) begin
                            state_n = DONE;
                        end
                    end
                end
                DONE: begin
                    // line_valid is high throughout DONE, so ready alone completes
                    if (line_ready) begin
                        state_n = IDLE;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // 4-way decoded word-slot write into the line register
    always_comb begin
        data_n = line_data;
        for (int k = 0; k < WORDS_PER_LINE; k++) begin
            if (slot_en[k]) begin
                data_n[k*WORD_W +: WORD_W] = mem_data;
            end
        end
    end

    // State register; outputs registered from the next-state decode
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            line_addr  <= '0;
            line_data  <= '0;
            fill_busy  <= 1'b0;
            mem_req    <= 1'b0;
            line_valid <= 1'b0;
            mem_addr   <= '0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            line_addr  <= addr_n;
            line_data  <= data_n;
            fill_busy  <= (state_n != IDLE);
            mem_req    <= (state_n == FILL);
            line_valid <= (state_n == DONE);
            mem_addr   <= {addr_n, idx_n};
        end
    end

endmodule

// File: tb/tb_line_fill_unit.sv
// Self-checking bench for line_fill_unit: directed scenarios with literal
// expectations plus a randomized run, all checked every cycle against a
// transaction-level model of the fill.
module tb_line_fill_unit;

    localparam int unsigned ADDR_W = 16;
    localparam int M_IMM   = 0;
    localparam int M_WAIT2 = 1;
    localparam int M_RAND  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                fill_req;
    logic [ADDR_W-3:0]   fill_addr;
    logic                fill_busy;
    logic                flush;
    logic                mem_req;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_ack = 1'b0;
    logic [15:0]         mem_data = 16'h0;
    logic                line_valid;
    logic                line_ready;
    logic [63:0]         line_data;
    logic [ADDR_W-3:0]   line_addr;

    line_fill_unit #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .fill_req(fill_req), .fill_addr(fill_addr),
        .fill_busy(fill_busy), .flush(flush), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .line_valid(line_valid), .line_ready(line_ready),
        .line_data(line_data), .line_addr(line_addr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Transaction-level model: a fill is "busy" from accept until handoff or
    // flush; m_count words have arrived; the line is offered once all four have.
    bit          m_busy = 1'b0;
    int          m_count = 0;
    logic [13:0] m_addr = '0;
    logic [15:0] m_words [4];

    always @(posedge clk) begin
        if (rst) begin
            m_busy  = 1'b0;
            m_count = 0;
            m_addr  = '0;
            for (int i = 0; i < 4; i++) m_words[i] = '0;
        end else if (flush) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (fill_req) begin
                m_busy  = 1'b1;
                m_addr  = fill_addr;
                m_count = 0;
            end
        end else if (m_count < 4) begin
            if (mem_ack) begin
                m_words[m_count] = mem_data;
                m_count++;
            end
        end else if (line_ready) begin
            m_busy = 1'b0;
        end
    end

    // Compare process: DUT outputs against the model every cycle
    always @(negedge clk) begin
        chk("fill_busy", 64'(fill_busy), 64'(m_busy));
        chk("mem_req", 64'(mem_req), 64'(m_busy && m_count < 4));
        chk("line_valid", 64'(line_valid), 64'(m_busy && m_count == 4));
        if (m_busy && m_count < 4)
            chk("mem_addr", 64'(mem_addr), 64'({m_addr, 2'(m_count)}));
        if (m_busy && m_count == 4) begin
            chk("line_data", line_data, {m_words[3], m_words[2], m_words[1], m_words[0]});
            chk("line_addr", 64'(line_addr), 64'(m_addr));
        end
    end

    // Memory responder: immediate, 2-wait-state or random acks
    logic [15:0] rq[$];
    int resp_mode = M_IMM;
    int wait_cnt = 0;
    int last_ack_cyc = 0;

    always @(negedge clk) begin
        #1;
        if (resp_mode == M_RAND) begin
            mem_ack  = ($urandom_range(0, 1) == 1);
            mem_data = 16'($urandom);
        end else if (!mem_req) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end else if (wait_cnt >= ((resp_mode == M_WAIT2) ? 2 : 0)) begin
            mem_ack = 1'b1;
            if (rq.size() > 0) mem_data = rq.pop_front();
            else mem_data = 16'($urandom);
            wait_cnt = 0;
            last_ack_cyc = cyc;
        end else begin
            mem_ack = 1'b0;
            wait_cnt++;
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_valid(input int budget, input string nm);
        int n = 0;
        while (line_valid !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk(nm, 64'(line_valid), 64'd1);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_busy"}, 64'(fill_busy), 64'd0);
        chk({nm, "_mem_req"}, 64'(mem_req), 64'd0);
        chk({nm, "_mem_addr"}, 64'(mem_addr), 64'd0);
        chk({nm, "_valid"}, 64'(line_valid), 64'd0);
        chk({nm, "_data"}, line_data, 64'd0);
        chk({nm, "_laddr"}, 64'(line_addr), 64'd0);
    endtask

    int v1;

    initial begin
        rst = 1'b1; fill_req = 1'b0; fill_addr = '0; flush = 1'b0; line_ready = 1'b0;
        step(); step();
        chk_reset_vals("reset");
        rst = 1'b0;
        step();

        // Basic fill, immediate acks
        rq = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
        line_ready = 1'b1; fill_req = 1'b1; fill_addr = 14'h0012;
        step();
        fill_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("basic_mem_addr", 64'(mem_addr), 64'(16'h0048 + k));
            step();
        end
        chk("basic_valid_c5", 64'(line_valid), 64'd1);
        chk("basic_line_data", line_data, 64'h4444_3333_2222_1111);
        chk("basic_line_addr", 64'(line_addr), 64'h0012);
        step();
        chk("basic_busy_after", 64'(fill_busy), 64'd0);

        // Wait states then backpressure
        resp_mode = M_WAIT2;
        rq = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
        line_ready = 1'b0; fill_req = 1'b1; fill_addr = 14'h0012;
        step();
        fill_req = 1'b0;
        wait_valid(60, "wait_valid_timeout");
        chk("wait_line_data", line_data, 64'h4444_3333_2222_1111);
        chk("wait_valid_latency", 64'(cyc), 64'(last_ack_cyc + 1));
        resp_mode = M_IMM;
        rq = {16'hA0A0, 16'hB1B1, 16'hC2C2, 16'hD3D3};
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin fill_req = 1'b1; fill_addr = 14'h0ABC; end
            chk("bp_valid", 64'(line_valid), 64'd1);
            chk("bp_data", line_data, 64'h4444_3333_2222_1111);
            chk("bp_addr", 64'(line_addr), 64'h0012);
            step();
        end
        line_ready = 1'b1;
        step();
        chk("bp_idle_after_hs", 64'(fill_busy), 64'd0);
        step();
        chk("bp_new_accept", 64'(fill_busy), 64'd1);
        chk("bp_new_laddr", 64'(line_addr), 64'h0ABC);
        fill_req = 1'b0;
        wait_valid(20, "bp_second_timeout");
        chk("bp_second_data", line_data, 64'hD3D3_C2C2_B1B1_A0A0);
        step();

        // Flush coinciding with the 2nd ack
        rq = {16'hDEAD, 16'hBEEF};
        line_ready = 1'b0; fill_req = 1'b1; fill_addr = 14'h0300;
        step();
        fill_req = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_busy", 64'(fill_busy), 64'd0);
        chk("flush_mem_req", 64'(mem_req), 64'd0);
        for (int i = 0; i < 6; i++) begin
            chk("flush_no_valid", 64'(line_valid), 64'd0);
            step();
        end
        rq = {16'h0101, 16'h0202, 16'h0303, 16'h0404};
        line_ready = 1'b1; fill_req = 1'b1; fill_addr = 14'h0001;
        step();
        fill_req = 1'b0;
        wait_valid(20, "flush_refill_timeout");
        chk("flush_refill_data", line_data, 64'h0404_0303_0202_0101);
        chk("flush_refill_addr", 64'(line_addr), 64'h0001);
        step();

        // Reset while in DONE
        rq = {16'h5555, 16'h6666, 16'h7777, 16'h8888};
        line_ready = 1'b0; fill_req = 1'b1; fill_addr = 14'h1234;
        step();
        fill_req = 1'b0;
        wait_valid(20, "rst_done_timeout");
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_vals("rst_done");
        step();

        // Back-to-back fills with ready and request held high
        rq = {16'h1001, 16'h1002, 16'h1003, 16'h1004,
              16'h2001, 16'h2002, 16'h2003, 16'h2004};
        line_ready = 1'b1; fill_req = 1'b1; fill_addr = 14'h0555;
        step();
        fill_addr = 14'h0AAA;
        wait_valid(20, "b2b_first_timeout");
        chk("b2b_first_data", line_data, 64'h1004_1003_1002_1001);
        chk("b2b_first_addr", 64'(line_addr), 64'h0555);
        v1 = cyc;
        step();
        chk("b2b_gap_idle", 64'(fill_busy), 64'd0);
        wait_valid(20, "b2b_second_timeout");
        chk("b2b_second_data", line_data, 64'h2004_2003_2002_2001);
        chk("b2b_second_addr", 64'(line_addr), 64'h0AAA);
        chk("b2b_interval", 64'(cyc - v1), 64'd6);
        fill_req = 1'b0;
        step();

        // Randomized traffic
        resp_mode = M_RAND;
        for (int i = 0; i < 3000; i++) begin
            fill_req   = ($urandom_range(0, 1) == 1);
            fill_addr  = 14'($urandom);
            flush      = ($urandom_range(0, 31) == 0);
            line_ready = ($urandom_range(0, 1) == 1);
            rst        = ($urandom_range(0, 127) == 0);
            step();
        end
        rst = 1'b0; flush = 1'b0; fill_req = 1'b0;
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_fill_unit.md
# line_fill_unit

Upstream neighbour of the line word selector: fetches one 64-bit cache line from the 16-bit-wide main memory as four sequential word reads. It assembles the words bottom to top (word 0 in bits [15:0]) and presents the finished line to the cache with a valid/ready handshake. It is the only path by which the cache obtains line data on a miss.

## Interface
- ADDR_W, 16, word-address width of main memory; line address width is ADDR_W-2
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- fill_req  in  1  cache requests a line fill; accepted only when fill_busy is low
- fill_addr  in  ADDR_W-2  line address; sampled in the accept cycle
- fill_busy  out  1  high in every state except IDLE
- flush  in  1  abort the current fill and discard partial or finished data
- mem_req  out  1  memory read request, held until acknowledged
- mem_addr  out  ADDR_W  word address, equal to {line address, word index}
- mem_ack  in  1  memory acknowledge; mem_data is valid in the same cycle
- mem_data  in  16  read data
- line_valid  out  1  assembled line available
- line_ready  in  1  cache accepts the line
- line_data  out  64  assembled line; word k occupies bits [16k+15:16k]
- line_addr  out  ADDR_W-2  line address of line_data

## Operation
- States:
  - IDLE: accept fill_req, go to FILL.
  - FILL: issue reads until four acks are counted, go to DONE.
  - DONE: hold line_valid until line_ready, go to IDLE.
- Accept: in IDLE with fill_req=1, latch fill_addr, clear the 2-bit word index, and move to FILL. Any fill_req raised while busy is ignored; the requester must hold it.
- FILL:
  - mem_req=1 and mem_addr={latched addr, idx}.
  - On mem_ack: write mem_data into slot idx, then increment idx.
  - The ack with idx=3 moves the block to DONE. idx wraps to 0 and is unused thereafter.
- mem_ack is ignored outside FILL.
- DONE: line_valid=1, and line_data/line_addr stay stable. When line_valid and line_ready are both high, the transfer completes and the block returns to IDLE.
- Flush, in any state:
  - Next state is IDLE, mem_req and line_valid drop next cycle, and the data register is not updated that cycle.
  - A mem_ack coinciding with flush is discarded.
  - Flush has priority over fill_req, mem_ack and line_ready.
  - Memory tolerates withdrawal of mem_req.
- The data register is not cleared between fills. Slots not yet written hold stale data, which is invisible because line_valid is low.

## Timing
- Reset values: state IDLE, fill_busy=0, mem_req=0, mem_addr=0, line_valid=0, line_data=0, line_addr=0, idx=0.
- All outputs are registered or decoded from registered state only; there is no combinational path from any input to any output.
- Request at cycle 0 (accepted): mem_req is high from cycle 1. With mem_ack=1 every cycle, words are captured at cycles 1–4 and line_valid is high at cycle 5. Minimum fill latency is 5 cycles.
- mem_addr advances in the cycle after each ack. Back-to-back acks give consecutive addresses with no bubble.
- A line_ready that is already high when line_valid rises completes the handshake in that same cycle. fill_busy falls in the next cycle, and a new fill_req can be accepted in that cycle.
- rst asserted mid-fill or in DONE forces the reset values on the next edge, identical to flush plus clearing of the data and address registers.

## Structure
- Shared package: state enum (IDLE, FILL, DONE), the constant WORDS_PER_LINE=4, and the line width 64 / word width 16, shared with the cache and the word selector.
- Single module, no sub-modules. The word-slot write is a 4-way decoded enable on idx.

## Test plan
- Basic fill: fill_addr=0x0012, memory returns 0x1111, 0x2222, 0x3333, 0x4444 with immediate acks.
  - mem_addr sequence is 0x0048, 0x0049, 0x004A, 0x004B.
  - line_data=0x4444_3333_2222_1111 and line_addr=0x0012 at cycle 5.
- Wait states: memory delays each ack by 2 cycles.
  - mem_addr holds for the stalled cycles and line_data is identical.
  - line_valid rises one cycle after the 4th ack.
- Backpressure: line_ready held low for 10 cycles after line_valid.
  - line_valid and line_data are stable throughout.
  - A fill_req during this period is ignored until one cycle after the handshake.
- Flush mid-fill: flush coincides with the 2nd ack.
  - IDLE next cycle, mem_req=0, line_valid never rises.
  - A new fill of 0x0001 then returns correct data.
- Reset in DONE: rst while line_valid=1 leaves all outputs at their reset values on the next cycle.
- Back-to-back fills: line_ready held high with fill_req held high.
  - The second fill is accepted the cycle after the first handshake.
  - There is no data mixing between the two lines.
